// File: rtl/fp_add_arbiter_if.sv
// Bundle of the two request ports, two result ports and the shared adder port.
// Perf counter outputs exist only when FPADD_ARB_PERF_EN is defined.
interface fp_add_arbiter_if;
    // Handshake rule on every port: a transfer happens in a cycle where valid and
    // ready are both high. A requester holds its operands stable while valid waits.
    logic        r0_valid, r0_ready, r0_sub;
    logic [15:0] r0_a, r0_b;
    logic [1:0]  r0_rm;
    logic        r1_valid, r1_ready, r1_sub;
    logic [15:0] r1_a, r1_b;
    logic [1:0]  r1_rm;
    logic        o0_valid, o0_ready;
    logic [15:0] o0_s;
    logic        o1_valid, o1_ready;
    logic [15:0] o1_s;
    logic [15:0] fa_a, fa_b, fa_s;
    logic        fa_sub, fa_e, busy;
    logic [1:0]  fa_rm;
`ifdef FPADD_ARB_PERF_EN
    logic [15:0] perf_g0, perf_g1, perf_stall;

    modport slave (
        input  r0_valid, r0_a, r0_b, r0_sub, r0_rm, r1_valid, r1_a, r1_b, r1_sub, r1_rm,
        input  o0_ready, o1_ready, fa_s,
        output r0_ready, r1_ready, o0_valid, o0_s, o1_valid, o1_s,
        output fa_a, fa_b, fa_sub, fa_rm, fa_e, busy, perf_g0, perf_g1, perf_stall
    );
    modport master (
        output r0_valid, r0_a, r0_b, r0_sub, r0_rm, r1_valid, r1_a, r1_b, r1_sub, r1_rm,
        output o0_ready, o1_ready, fa_s,
        input  r0_ready, r1_ready, o0_valid, o0_s, o1_valid, o1_s,
        input  fa_a, fa_b, fa_sub, fa_rm, fa_e, busy, perf_g0, perf_g1, perf_stall
    );
`else
    modport slave (
        input  r0_valid, r0_a, r0_b, r0_sub, r0_rm, r1_valid, r1_a, r1_b, r1_sub, r1_rm,
        input  o0_ready, o1_ready, fa_s,
        output r0_ready, r1_ready, o0_valid, o0_s, o1_valid, o1_s,
        output fa_a, fa_b, fa_sub, fa_rm, fa_e, busy
    );
    modport master (
        output r0_valid, r0_a, r0_b, r0_sub, r0_rm, r1_valid, r1_a, r1_b, r1_sub, r1_rm,
        output o0_ready, o1_ready, fa_s,
        input  r0_ready, r1_ready, o0_valid, o0_s, o1_valid, o1_s,
        input  fa_a, fa_b, fa_sub, fa_rm, fa_e, busy
    );
`endif
endinterface

// File: rtl/fp_add_arbiter.sv
// Round-robin sharing of one 2-stage enable-gated fp16 adder between two requesters.
// Optional perf counters (perf_g0/perf_g1/perf_stall) under FPADD_ARB_PERF_EN.
module fp_add_arbiter #(
    parameter bit RR_INIT = 1'b1
) (
    input  logic           clk,
    input  logic           clrn,
    fp_add_arbiter_if.slave bus
);
    logic        t1_v_q, t1_v_d, t1_id_q, t1_id_d;
    logic        t2_v_q, t2_v_d, t2_id_q, t2_id_d;
    logic        last_q, last_d;
    logic        o0_valid_q, o0_valid_d, o1_valid_q, o1_valid_d;
    logic [15:0] o0_s_q, o0_s_d, o1_s_q, o1_s_d;
    logic        gnt_v, gnt_id, stall, fa_e, issue, cap0, cap1;

    always_comb begin
        gnt_v  = bus.r0_valid | bus.r1_valid;
        // With a single requester its id wins; with both, the one not served last.
        gnt_id = (bus.r0_valid & bus.r1_valid) ? ~last_q : bus.r1_valid;
        stall  = t2_v_q & (t2_id_q ? (o1_valid_q & ~bus.o1_ready)
                                   : (o0_valid_q & ~bus.o0_ready));
        fa_e   = ~stall;
        issue  = fa_e & gnt_v;
        cap0   = fa_e & t2_v_q & ~t2_id_q;
        cap1   = fa_e & t2_v_q & t2_id_q;

        t1_v_d     = t1_v_q;
        t1_id_d    = t1_id_q;
        t2_v_d     = t2_v_q;
        t2_id_d    = t2_id_q;
        last_d     = last_q;
        o0_valid_d = o0_valid_q;
        o0_s_d     = o0_s_q;
        o1_valid_d = o1_valid_q;
        o1_s_d     = o1_s_q;

        if (fa_e) begin
            t1_v_d  = issue;
            t1_id_d = gnt_id;
            t2_v_d  = t1_v_q;
            t2_id_d = t1_id_q;
        end
        if (issue) last_d = gnt_id;

        // A capture wins over a drain so back-to-back results never leave a bubble.
        if (cap0) begin
            o0_valid_d = 1'b1;
            o0_s_d     = bus.fa_s;
        end else if (bus.o0_ready) begin
            o0_valid_d = 1'b0;
        end
        if (cap1) begin
            o1_valid_d = 1'b1;
            o1_s_d     = bus.fa_s;
        end else if (bus.o1_ready) begin
            o1_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            t1_v_q     <= 1'b0;
            t1_id_q    <= 1'b0;
            t2_v_q     <= 1'b0;
            t2_id_q    <= 1'b0;
            last_q     <= RR_INIT;
            o0_valid_q <= 1'b0;
            o0_s_q     <= 16'h0000;
            o1_valid_q <= 1'b0;
            o1_s_q     <= 16'h0000;
        end else begin
            t1_v_q     <= t1_v_d;
            t1_id_q    <= t1_id_d;
            t2_v_q     <= t2_v_d;
            t2_id_q    <= t2_id_d;
            last_q     <= last_d;
            o0_valid_q <= o0_valid_d;
            o0_s_q     <= o0_s_d;
            o1_valid_q <= o1_valid_d;
            o1_s_q     <= o1_s_d;
        end
    end

    always_comb begin
        bus.fa_a   = 16'h0000;
        bus.fa_b   = 16'h0000;
        bus.fa_sub = 1'b0;
        bus.fa_rm  = 2'b00;
        if (gnt_v) begin
            if (gnt_id) begin
                bus.fa_a   = bus.r1_a;
                bus.fa_b   = bus.r1_b;
                bus.fa_sub = bus.r1_sub;
                bus.fa_rm  = bus.r1_rm;
            end else begin
                bus.fa_a   = bus.r0_a;
                bus.fa_b   = bus.r0_b;
                bus.fa_sub = bus.r0_sub;
                bus.fa_rm  = bus.r0_rm;
            end
        end
    end

    assign bus.fa_e     = fa_e;
    assign bus.r0_ready = fa_e & gnt_v & ~gnt_id;
    assign bus.r1_ready = fa_e & gnt_v & gnt_id;
    assign bus.o0_valid = o0_valid_q;
    assign bus.o0_s     = o0_s_q;
    assign bus.o1_valid = o1_valid_q;
    assign bus.o1_s     = o1_s_q;
    assign bus.busy     = t1_v_q | t2_v_q | o0_valid_q | o1_valid_q;

`ifdef FPADD_ARB_PERF_EN
    logic [15:0] perf_g0_q, perf_g1_q, perf_stall_q;

    // Counters wrap naturally at 16 bits.
    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            perf_g0_q    <= 16'h0000;
            perf_g1_q    <= 16'h0000;
            perf_stall_q <= 16'h0000;
        end else begin
            if (issue & ~gnt_id) perf_g0_q <= perf_g0_q + 16'd1;
            if (issue & gnt_id)  perf_g1_q <= perf_g1_q + 16'd1;
            if (stall)           perf_stall_q <= perf_stall_q + 16'd1;
        end
    end

    assign bus.perf_g0    = perf_g0_q;
    assign bus.perf_g1    = perf_g1_q;
    assign bus.perf_stall = perf_stall_q;
`endif
endmodule

// File: tb/tb_fp_add_arbiter.sv
// Bench for fp_add_arbiter: behavioural 2-stage fp16 adder, per-requester scoreboards.
// Perf counter checks compile in when FPADD_ARB_PERF_EN is defined.
module tb_fp_add_arbiter;
    logic clk = 1'b0;
    logic clrn;
    always #5 clk = ~clk;

    fp_add_arbiter_if bus();
    fp_add_arbiter #(.RR_INIT(1'b1)) dut (.clk(clk), .clrn(clrn), .bus(bus));

    // Reference fp16 add for normal operands, round to nearest even (rm not modelled).
    function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b_in,
                                             input logic sub);
        logic [15:0] b, x, y;
        logic [27:0] mx, my, sum;
        logic [11:0] m;
        logic        up;
        int          ex, d;
        b = b_in ^ {sub, 15'b0};
        if (a[14:0] >= b[14:0]) begin x = a; y = b; end
        else begin x = b; y = a; end
        if (y[14:0] == 15'd0) return x;
        ex = int'(x[14:10]);
        d  = ex - int'(y[14:10]);
        mx = {2'b01, x[9:0], 16'b0};
        my = {2'b01, y[9:0], 16'b0};
        if (d > 26) my = 28'd1;
        else if (d > 0) my = (my >> d) | (((my & ((28'd1 << d) - 28'd1)) != 28'd0) ? 28'd1 : 28'd0);
        sum = (x[15] == y[15]) ? mx + my : mx - my;
        if (sum == 28'd0) return 16'h0000;
        if (sum[27]) begin
            sum = (sum >> 1) | {27'b0, sum[0]};
            ex++;
        end
        while (!sum[26]) begin
            sum = sum << 1;
            ex--;
        end
        up = sum[15] & ((|sum[14:0]) | sum[16]);
        m  = {1'b0, sum[26:16]} + {11'b0, up};
        if (m[11]) begin
            m = m >> 1;
            ex++;
        end
        return {x[15], ex[4:0], m[9:0]};
    endfunction

    function automatic logic [15:0] rnd_fp();
        logic [4:0] e;
        logic [9:0] f;
        logic       s;
        s = 1'($urandom_range(0, 1));
        e = 5'($urandom_range(12, 18));
        f = 10'($urandom_range(0, 1023));
        return {s, e, f};
    endfunction

    // Behavioural shared adder: two enable-gated stages, reset from the same source.
    logic [15:0] add_s1_q, add_s2_q;
    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            add_s1_q <= 16'h0000;
            add_s2_q <= 16'h0000;
        end else if (bus.fa_e) begin
            add_s1_q <= fp16_add(bus.fa_a, bus.fa_b, bus.fa_sub);
            add_s2_q <= add_s1_q;
        end
    end
    assign bus.fa_s = add_s2_q;

    logic [15:0] exp_q0[$];
    logic [15:0] exp_q1[$];
    int errors = 0;
    int checks = 0;
    int pops0, pops1, stalls, acc1;
    logic        obs_r0_ready, obs_r1_ready, obs_o0_valid, obs_o1_valid, obs_fa_e, obs_busy;
    logic [15:0] obs_o0_s;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic drive_r0(input logic v, input logic [15:0] a, input logic [15:0] b,
                            input logic sub, input logic [1:0] rm);
        bus.r0_valid = v; bus.r0_a = a; bus.r0_b = b; bus.r0_sub = sub; bus.r0_rm = rm;
    endtask

    task automatic drive_r1(input logic v, input logic [15:0] a, input logic [15:0] b,
                            input logic sub, input logic [1:0] rm);
        bus.r1_valid = v; bus.r1_a = a; bus.r1_b = b; bus.r1_sub = sub; bus.r1_rm = rm;
    endtask

    task automatic idle_reqs();
        drive_r0(1'b0, 16'h0, 16'h0, 1'b0, 2'b0);
        drive_r1(1'b0, 16'h0, 16'h0, 1'b0, 2'b0);
    endtask

    // Called at negedge+1 after inputs are set; observes at negedge+2, returns one cycle later.
    task automatic tick();
        #1;
        obs_r0_ready = bus.r0_ready;
        obs_r1_ready = bus.r1_ready;
        obs_o0_valid = bus.o0_valid;
        obs_o1_valid = bus.o1_valid;
        obs_o0_s     = bus.o0_s;
        obs_fa_e     = bus.fa_e;
        obs_busy     = bus.busy;
        check("ready_excl", 64'(bus.r0_ready & bus.r1_ready), 64'd0);
        if (bus.r0_ready) begin
            check("fa_bus_r0", {bus.fa_a, bus.fa_b, bus.fa_sub, bus.fa_rm},
                  {bus.r0_a, bus.r0_b, bus.r0_sub, bus.r0_rm});
            exp_q0.push_back(fp16_add(bus.r0_a, bus.r0_b, bus.r0_sub));
        end
        if (bus.r1_ready) begin
            check("fa_bus_r1", {bus.fa_a, bus.fa_b, bus.fa_sub, bus.fa_rm},
                  {bus.r1_a, bus.r1_b, bus.r1_sub, bus.r1_rm});
            exp_q1.push_back(fp16_add(bus.r1_a, bus.r1_b, bus.r1_sub));
        end
        if (!bus.r0_valid && !bus.r1_valid)
            check("fa_bubble", {bus.fa_a, bus.fa_b, bus.fa_sub, bus.fa_rm}, 64'd0);
        if (bus.o0_valid && bus.o0_ready) begin
            if (exp_q0.size() == 0) check("o0_unexpected", {48'd0, bus.o0_s}, 64'hdead);
            else check("o0_s", bus.o0_s, exp_q0.pop_front());
            pops0++;
        end
        if (bus.o1_valid && bus.o1_ready) begin
            if (exp_q1.size() == 0) check("o1_unexpected", {48'd0, bus.o1_s}, 64'hdead);
            else check("o1_s", bus.o1_s, exp_q1.pop_front());
            pops1++;
        end
        if (!bus.fa_e) stalls++;
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_reqs();
        clrn = 1'b1;
        exp_q0.delete();
        exp_q1.delete();
        @(posedge clk);
        @(negedge clk);
        clrn = 1'b0;
        #1;
    endtask

    task automatic drain(input string tag, input int budget);
        idle_reqs();
        bus.o0_ready = 1'b1;
        bus.o1_ready = 1'b1;
        for (int i = 0; i < budget && (exp_q0.size() != 0 || exp_q1.size() != 0 || bus.busy); i++)
            tick();
        check(tag, {exp_q0.size() != 0, exp_q1.size() != 0, bus.busy}, 64'd0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a, b;
        clrn = 1'b1;
        idle_reqs();
        bus.o0_ready = 1'b1;
        bus.o1_ready = 1'b1;
        #1;
        check("rst_valid", {bus.o0_valid, bus.o1_valid}, 64'd0);
        check("rst_s", {bus.o0_s, bus.o1_s}, 64'd0);
        check("rst_fa_e", 64'(bus.fa_e), 64'd1);
        check("rst_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        clrn = 1'b0;
        #1;
        check("rst_ready_idle", {bus.r0_ready, bus.r1_ready}, 64'd0);

        // Single op: 1.0 + 2.0 = 3.0, three cycles of latency.
        drive_r0(1'b1, 16'h3C00, 16'h4000, 1'b0, 2'b00);
        tick();
        check("single_r0_ready", 64'(obs_r0_ready), 64'd1);
        idle_reqs();
        tick();
        check("single_o0v_c1", 64'(obs_o0_valid), 64'd0);
        tick();
        check("single_o0v_c2", 64'(obs_o0_valid), 64'd0);
        tick();
        check("single_o0v_c3", 64'(obs_o0_valid), 64'd1);
        check("single_o0_s", 64'(obs_o0_s), 64'h4200);
        tick();
        check("single_busy_c4", 64'(obs_busy), 64'd0);

        // Fair share from reset: grants alternate 0,1,0,1,0,1.
        do_reset();
        pops0 = 0;
        pops1 = 0;
        for (int i = 0; i < 6; i++) begin
            drive_r0(1'b1, 16'h4000, 16'h3C00, 1'b1, 2'b00);
            drive_r1(1'b1, 16'h3C00, 16'h3C00, 1'b0, 2'b00);
            tick();
            check("fair_gnt", {obs_r0_ready, obs_r1_ready}, (i % 2 == 0) ? 64'd2 : 64'd1);
        end
        drain("fair_drain", 20);
        check("fair_cnt0", 64'(pops0), 64'd3);
        check("fair_cnt1", 64'(pops1), 64'd3);

        // Backpressure on requester 1; r0 offered during the stall must not be accepted.
        pops1 = 0;
        stalls = 0;
        acc1 = 0;
        a = rnd_fp();
        b = rnd_fp();
        for (int c = 0; c < 40 && pops1 < 4; c++) begin
            drive_r1(acc1 < 4, a, b, 1'b0, 2'b01);
            drive_r0(c >= 3 && c <= 6, 16'h4400, 16'h3C00, 1'b0, 2'b00);
            bus.o1_ready = (c < 2 || c >= 7);
            tick();
            if (c == 2) check("bp_fa_e_c2", 64'(obs_fa_e), 64'd1);
            if (c >= 3 && c <= 6) begin
                check("bp_stall", 64'(obs_fa_e), 64'd0);
                check("bp_ready_stall", {obs_r0_ready, obs_r1_ready}, 64'd0);
            end
            if (obs_r1_ready) begin
                acc1++;
                a = rnd_fp();
                b = rnd_fp();
            end
        end
        drain("bp_drain", 20);
        check("bp_pops1", 64'(pops1), 64'd4);
        check("bp_stalls", 64'(stalls), 64'd4);

        // Back-to-back r0 with o0_ready held: no bubble on o0_valid, no stall.
        bus.o0_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            drive_r0(c < 6, rnd_fp(), rnd_fp(), 1'($urandom_range(0, 1)),
                     2'($urandom_range(0, 3)));
            tick();
            check("b2b_fa_e", 64'(obs_fa_e), 64'd1);
            if (c >= 3 && c <= 8) check("b2b_o0v", 64'(obs_o0_valid), 64'd1);
        end
        drain("b2b_drain", 20);

        // Reset with two ops in flight and a held result.
        bus.o0_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            drive_r0(c == 0 || c == 3 || c == 4, rnd_fp(), rnd_fp(), 1'b0, 2'b00);
            tick();
        end
        check("mid_pre_o0v", 64'(obs_o0_valid), 64'd1);
        idle_reqs();
        clrn = 1'b1;
        #1;
        check("mid_rst_valid", {bus.o0_valid, bus.o1_valid}, 64'd0);
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
        check("mid_rst_fa_e", 64'(bus.fa_e), 64'd1);
        exp_q0.delete();
        exp_q1.delete();
        @(negedge clk);
        clrn = 1'b0;
        #1;
        pops0 = 0;
        bus.o0_ready = 1'b1;
        drive_r0(1'b1, 16'h4200, 16'h3C00, 1'b0, 2'b00);
        drive_r1(1'b1, 16'h4000, 16'h4000, 1'b0, 2'b00);
        tick();
        check("mid_first_gnt", {obs_r0_ready, obs_r1_ready}, 64'd2);
        drive_r0(1'b0, 16'h0, 16'h0, 1'b0, 2'b00);
        tick();
        check("mid_second_gnt", {obs_r0_ready, obs_r1_ready}, 64'd1);
        drain("mid_drain", 20);
        check("mid_pops0", 64'(pops0), 64'd1);

`ifdef FPADD_ARB_PERF_EN
        // 5 grants to r0, 3 to r1, 4 stall cycles.
        do_reset();
        for (int c = 0; c < 5; c++) begin
            drive_r0(1'b1, rnd_fp(), rnd_fp(), 1'b0, 2'b00);
            tick();
        end
        idle_reqs();
        for (int c = 0; c < 10; c++) begin
            drive_r1(c < 3, rnd_fp(), rnd_fp(), 1'b1, 2'b00);
            bus.o1_ready = (c >= 7);
            tick();
        end
        drain("perf_drain", 20);
        check("perf_g0", 64'(bus.perf_g0), 64'd5);
        check("perf_g1", 64'(bus.perf_g1), 64'd3);
        check("perf_stall", 64'(bus.perf_stall), 64'd4);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fp_add_arbiter.md
Name: fp_add_arbiter

Overview:
- Sequences and shares one 16-bit pipelined fp adder (2 internal register stages, enable-gated) between two requesters.
- Round-robin arbitration on valid/ready request ports.
- Tracks each in-flight op's owner with a tag pipe aligned to the adder stages.
- Returns results through per-requester one-entry output registers; stalls the shared adder via its enable when a destination register is full.

Parameters:
- RR_INIT, 1, requester id treated as "last granted" after reset (1 -> requester 0 wins first tie).

Ports:
- clk  in  1  clock
- clrn  in  1  asynchronous, active-high reset
- r0_valid / r1_valid  in  1  request valid
- r0_ready / r1_ready  out  1  request accepted this cycle
- r0_a, r0_b / r1_a, r1_b  in  16  operands
- r0_sub / r1_sub  in  1  1 = subtract
- r0_rm / r1_rm  in  2  round mode
- o0_valid / o1_valid  out  1  result valid
- o0_ready / o1_ready  in  1  result consumed
- o0_s / o1_s  out  16  result
- fa_a, fa_b  out  16  adder operands
- fa_sub  out  1  adder sub
- fa_rm  out  2  adder round mode
- fa_e  out  1  adder pipeline enable
- fa_s  in  16  adder result (combinational from adder's 2nd register)
- busy  out  1  any op in flight or any result held

Behaviour:
- Reset (async, clrn=1):
  - t1_v=t2_v=0, t1_id=t2_id=0, last=RR_INIT.
  - o0_valid=o1_valid=0, o0_s=o1_s=0.
  - Outputs: fa_e=1, busy=0.
  - Integration drives the adder's reset from the same source (inverted for the adder), so in-flight ops are discarded on reset mid-operation.
- Stall:
  - stall = t2_v & oX_valid & ~oX_ready, where X = t2_id.
  - fa_e = ~stall (combinational).
- Grant (combinational):
  - Only one requester valid -> that one.
  - Both valid -> the requester != last.
  - None valid -> no grant.
- Issue:
  - issue = fa_e & (r0_valid | r1_valid).
  - rX_ready = fa_e & grant==X; never both high.
  - fa_a/fa_b/fa_sub/fa_rm mux from the granted requester.
  - No grant -> drive all zero (bubble).
  - last <= granted id only on issue.
- Tag pipe (advances only when fa_e=1):
  - t1 <= {issue, gnt_id}; t2 <= t1.
  - When fa_e=0, tags and adder registers hold; fa_s stays stable.
- Capture:
  - When fa_e & t2_v: oX_s <= fa_s, oX_valid <= 1, X = t2_id.
  - Drain: oX_valid & oX_ready without capture to X -> oX_valid <= 0.
  - Simultaneous drain and capture to the same X -> oX_valid stays 1, oX_s = new value (no bubble, no stall).
  - Output registers hold value and valid while ~oX_ready.
- Latency:
  - Request accepted in cycle t -> oX_valid first high in cycle t+3 when no stall.
  - Each stall cycle adds one cycle.
- Throughput: 1 op/cycle aggregate; both requesters continuously valid -> grants alternate 0,1,0,1.
- Ordering: results per requester return in issue order. A full output slot for one requester stalls the whole adder (head-of-line blocking is accepted).
- busy = t1_v | t2_v | o0_valid | o1_valid.

Optional Feature:
- Macro: FPADD_ARB_PERF_EN.
- Defined:
  - Adds outputs perf_g0, perf_g1 (16-bit, increment on each issue to that requester) and perf_stall (16-bit, increments each cycle stall=1).
  - All counters wrap 0xFFFF -> 0x0000 and reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Single op: r0 a=0x3C00 b=0x4000 sub=0 rm=0, o0_ready=1 -> r0_ready in cycle 0, o0_valid cycle 3, o0_s=0x4200; busy low from cycle 4.
- Fair share: r0 and r1 both valid 6 cycles (r0: 0x4000-0x3C00 sub=1; r1: 0x3C00+0x3C00) -> grants 0,1,0,1,0,1. o0_s=0x3C00, o1_s=0x4000, 3 results each in order.
- Backpressure: r1 streams 4 ops, o1_ready=0 from cycle 2 -> fa_e low once 2nd result reaches t2; r0_ready=r1_ready=0 while stalled. Raising o1_ready yields all 4 results in order, none lost or duplicated.
- Drain+capture: o0_ready=1 held, r0 back-to-back -> o0_valid continuously 1 for consecutive results, fa_e never low.
- Reset mid-operation: assert clrn with 2 ops in flight and o0_valid=1 -> all valid flags 0 immediately (async). After release no stale result appears; the first grant goes to requester 0.
- PERF (macro defined): 5 grants to r0, 3 to r1, 4 stall cycles -> perf_g0=5, perf_g1=3, perf_stall=4.
